// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: field extraction, register read with write-back bypass,
// load-use hazard stall, flush, sticky halt and an ID/EX register with valid/ready handshake.
module id_stage_pipe #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned RA_W   = $clog2(NREG),
   parameter int unsigned CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst,
   input  logic [XLEN-1:0]   in_pc4,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_imm_unsigned,
   input  logic              wb_we,
   input  logic [RA_W-1:0]   wb_num,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              halt_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_rs_data,
   output logic [XLEN-1:0]   out_rt_data,
   output logic [XLEN-1:0]   out_imm,
   output logic [XLEN-1:0]   out_pc4,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [RA_W-1:0]   out_dst,
   output logic [RA_W-1:0]   out_rs_num,
   output logic [RA_W-1:0]   out_rt_num,
   output logic [4:0]        out_shamt,
   output logic [5:0]        out_funct,
   output logic              halted
);

   logic [XLEN-1:0]   rf_q [NREG];
   logic              valid_q, valid_d;
   logic              halted_q;
   logic [XLEN-1:0]   rs_data_q, rt_data_q, imm_q, pc4_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [RA_W-1:0]   dst_q, rs_num_q, rt_num_q;
   logic [4:0]        shamt_q;
   logic [5:0]        funct_q;

   logic [RA_W-1:0]   rs_idx, rt_idx, rd_idx, dst_idx;
   logic [XLEN-1:0]   rs_data, rt_data, imm;
   logic              hazard, adv, xfer, wb_hit_ok;
   logic              unused_opcode;

   assign unused_opcode = ^in_inst[31:26];

   assign rs_idx = RA_W'(in_inst[25:21]);
   assign rt_idx = RA_W'(in_inst[20:16]);
   assign rd_idx = RA_W'(in_inst[15:11]);

   always_comb begin
      dst_idx = '0;
      unique case (in_ctrl[3:2])
         2'b00:   dst_idx = rt_idx;
         2'b01:   dst_idx = rd_idx;
         2'b10:   dst_idx = RA_W'(NREG - 1);
         default: dst_idx = '0;
      endcase
   end

   // Write-first bypass: a same-cycle write-back overrides the stored value.
   assign wb_hit_ok = wb_we && (wb_num != '0);
   assign rs_data = (rs_idx == '0) ? '0 :
                    (wb_hit_ok && (wb_num == rs_idx)) ? wb_data : rf_q[rs_idx];
   assign rt_data = (rt_idx == '0) ? '0 :
                    (wb_hit_ok && (wb_num == rt_idx)) ? wb_data : rf_q[rt_idx];

   assign imm = in_imm_unsigned ? {{(XLEN-16){1'b0}}, in_inst[15:0]}
                                : {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};

   // Load in ID/EX whose destination feeds this instruction: stall one cycle.
   assign hazard = valid_q & ctrl_q[1] & (dst_q != '0) &
                   ((dst_q == rs_idx) | (dst_q == rt_idx));
   assign adv      = ~valid_q | out_ready;
   assign in_ready = ~rst_b & ~flush & ~halted_q & ~hazard & adv;
   assign xfer     = in_valid & in_ready;

   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (adv) begin
         valid_d = xfer;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_hit_ok && !halted_q) begin
         rf_q[wb_num] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         pc4_q     <= '0;
         ctrl_q    <= '0;
         dst_q     <= '0;
         rs_num_q  <= '0;
         rt_num_q  <= '0;
         shamt_q   <= '0;
         funct_q   <= '0;
      end else begin
         valid_q  <= valid_d;
         halted_q <= halted_q | halt_in;
         if (xfer) begin
            rs_data_q <= rs_data;
            rt_data_q <= rt_data;
            imm_q     <= imm;
            pc4_q     <= in_pc4;
            ctrl_q    <= in_ctrl;
            dst_q     <= dst_idx;
            rs_num_q  <= rs_idx;
            rt_num_q  <= rt_idx;
            shamt_q   <= in_inst[10:6];
            funct_q   <= in_inst[5:0];
         end
      end
   end

   assign out_valid   = valid_q;
   assign out_rs_data = rs_data_q;
   assign out_rt_data = rt_data_q;
   assign out_imm     = imm_q;
   assign out_pc4     = pc4_q;
   assign out_ctrl    = ctrl_q;
   assign out_dst     = dst_q;
   assign out_rs_num  = rs_num_q;
   assign out_rt_num  = rt_num_q;
   assign out_shamt   = shamt_q;
   assign out_funct   = funct_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: expected ID/EX contents are queued on acceptance
// and compared when the execute stage consumes them.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst_b, flush, in_valid, in_ready, in_imm_unsigned;
   logic [31:0] in_inst, in_pc4, wb_data;
   logic [7:0]  in_ctrl;
   logic        wb_we, halt_in, out_valid, out_ready, halted;
   logic [4:0]  wb_num, out_dst, out_rs_num, out_rt_num, out_shamt;
   logic [31:0] out_rs_data, out_rt_data, out_imm, out_pc4;
   logic [7:0]  out_ctrl;
   logic [5:0]  out_funct;

   always #5 clk = ~clk;

   id_stage_pipe dut (
      .clk(clk), .rst_b(rst_b), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc4(in_pc4), .in_ctrl(in_ctrl),
      .in_imm_unsigned(in_imm_unsigned), .wb_we(wb_we), .wb_num(wb_num), .wb_data(wb_data),
      .halt_in(halt_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
      .out_pc4(out_pc4), .out_ctrl(out_ctrl), .out_dst(out_dst), .out_rs_num(out_rs_num),
      .out_rt_num(out_rt_num), .out_shamt(out_shamt), .out_funct(out_funct), .halted(halted)
   );

   typedef struct packed {
      logic [31:0] rs_data, rt_data, imm, pc4;
      logic [7:0]  ctrl;
      logic [4:0]  dst, rs, rt, shamt;
      logic [5:0]  funct;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_rf [32];
   bit          model_halted;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
      return {op, rs, rt, im};
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (wb_we && wb_num == idx) return wb_data;
      return model_rf[idx];
   endfunction

   function automatic exp_t predict();
      exp_t e;
      e.rs    = in_inst[25:21];
      e.rt    = in_inst[20:16];
      e.shamt = in_inst[10:6];
      e.funct = in_inst[5:0];
      case (in_ctrl[3:2])
         2'b00:   e.dst = in_inst[20:16];
         2'b01:   e.dst = in_inst[15:11];
         2'b10:   e.dst = 5'd31;
         default: e.dst = 5'd0;
      endcase
      e.imm     = in_imm_unsigned ? {16'h0, in_inst[15:0]} : {{16{in_inst[15]}}, in_inst[15:0]};
      e.rs_data = model_read(e.rs);
      e.rt_data = model_read(e.rt);
      e.pc4     = in_pc4;
      e.ctrl    = in_ctrl;
      return e;
   endfunction

   task automatic cmp_out(input exp_t e);
      check("rs_data", out_rs_data, e.rs_data);
      check("rt_data", out_rt_data, e.rt_data);
      check("imm", out_imm, e.imm);
      check("pc4", out_pc4, e.pc4);
      check("ctrl", {24'h0, out_ctrl}, {24'h0, e.ctrl});
      check("dst", {27'h0, out_dst}, {27'h0, e.dst});
      check("rs_num", {27'h0, out_rs_num}, {27'h0, e.rs});
      check("rt_num", {27'h0, out_rt_num}, {27'h0, e.rt});
      check("shamt", {27'h0, out_shamt}, {27'h0, e.shamt});
      check("funct", {26'h0, out_funct}, {26'h0, e.funct});
   endtask

   // One clock: sample at the falling edge, then advance the reference model at the rising edge.
   task automatic tick(input bit exp_rdy);
      @(negedge clk);
      if (in_valid) begin
         check("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
         if (exp_rdy) exp_q.push_back(predict());
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("spurious_out_valid", {31'h0, out_valid}, 32'h0);
         else cmp_out(exp_q.pop_front());
      end
      @(posedge clk);
      if (rst_b) begin
         for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
         model_halted = 1'b0;
      end else begin
         if (wb_we && wb_num != 5'd0 && !model_halted) model_rf[wb_num] = wb_data;
         if (halt_in) model_halted = 1'b1;
      end
      #1;
   endtask

   initial begin
      rst_b = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc4 = '0; in_ctrl = '0;
      in_imm_unsigned = 1'b0; wb_we = 1'b0; wb_num = '0; wb_data = '0; halt_in = 1'b0;
      out_ready = 1'b1; model_halted = 1'b0;
      tick(1'b0);
      tick(1'b0);
      check("rst_in_ready", {31'h0, in_ready}, 32'h0);
      check("rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);
      check("rst_out_rs_data", out_rs_data, 32'h0);
      check("rst_out_ctrl", {24'h0, out_ctrl}, 32'h0);

      // Register write then read back.
      rst_b = 1'b0;
      wb_we = 1'b1; wb_num = 5'd5; wb_data = 32'h0000_1234;
      tick(1'b0);
      wb_we = 1'b0;
      in_valid = 1'b1; in_inst = mk_r(5'd5, 5'd0, 5'd9, 5'd3, 6'h21);
      in_pc4 = 32'h104; in_ctrl = 8'h05;
      tick(1'b1);
      check("first_out_valid", {31'h0, out_valid}, 32'h1);
      check("first_rs_data", out_rs_data, 32'h0000_1234);

      // Same-cycle bypass, then a write to r0 that must read back as zero.
      wb_we = 1'b1; wb_num = 5'd7; wb_data = 32'hDEAD_BEEF;
      in_inst = mk_r(5'd7, 5'd0, 5'd2, 5'd0, 6'h20); in_pc4 = 32'h108;
      tick(1'b1);
      check("bypass_rs_data", out_rs_data, 32'hDEAD_BEEF);
      wb_num = 5'd0; wb_data = 32'h0000_FFFF;
      in_inst = mk_r(5'd0, 5'd7, 5'd2, 5'd0, 6'h20); in_pc4 = 32'h10C;
      tick(1'b1);
      check("r0_reads_zero", out_rs_data, 32'h0);
      wb_we = 1'b0; in_valid = 1'b0;
      tick(1'b0);

      // Load-use hazard: one refused cycle, one bubble, with a write-back during the stall.
      in_valid = 1'b1; in_inst = mk_i(6'h23, 5'd1, 5'd3, 16'h0010); in_ctrl = 8'h03;
      in_pc4 = 32'h200;
      tick(1'b1);
      in_inst = mk_r(5'd3, 5'd2, 5'd4, 5'd0, 6'h20); in_ctrl = 8'h05; in_pc4 = 32'h204;
      wb_we = 1'b1; wb_num = 5'd3; wb_data = 32'hCAFE_F00D;
      tick(1'b0);
      check("hazard_bubble", {31'h0, out_valid}, 32'h0);
      wb_we = 1'b0;
      tick(1'b1);
      check("post_hazard_valid", {31'h0, out_valid}, 32'h1);

      // Back-pressure: four held cycles with stable outputs.
      out_ready = 1'b0;
      in_inst = mk_r(5'd4, 5'd5, 5'd6, 5'd1, 6'h22); in_pc4 = 32'h208;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0);
         check("hold_valid", {31'h0, out_valid}, 32'h1);
         if (exp_q.size() == 0) check("hold_queue", {31'h0, out_valid}, 32'h0);
         else begin
            check("hold_rs_data", out_rs_data, exp_q[0].rs_data);
            check("hold_pc4", out_pc4, exp_q[0].pc4);
            check("hold_dst", {27'h0, out_dst}, {27'h0, exp_q[0].dst});
         end
      end
      out_ready = 1'b1;
      tick(1'b1);
      check("release_valid", {31'h0, out_valid}, 32'h1);
      in_valid = 1'b0;
      tick(1'b0);

      // Immediate extension and destination selects.
      in_valid = 1'b1; in_inst = mk_i(6'h08, 5'd2, 5'd7, 16'h8001); in_ctrl = 8'hA9;
      in_imm_unsigned = 1'b0; in_pc4 = 32'h300;
      tick(1'b1);
      check("imm_signed", out_imm, 32'hFFFF_8001);
      check("dst_ra", {27'h0, out_dst}, 32'd31);
      in_imm_unsigned = 1'b1; in_ctrl = 8'h0C; in_pc4 = 32'h304;
      tick(1'b1);
      check("imm_unsigned", out_imm, 32'h0000_8001);
      check("dst_zero", {27'h0, out_dst}, 32'd0);
      in_valid = 1'b0; in_imm_unsigned = 1'b0;
      tick(1'b0);
      check("drain_valid", {31'h0, out_valid}, 32'h0);

      // Flush during a hazard.
      in_valid = 1'b1; in_inst = mk_i(6'h23, 5'd1, 5'd6, 16'h0004); in_ctrl = 8'h03;
      in_pc4 = 32'h400;
      tick(1'b1);
      in_inst = mk_r(5'd6, 5'd0, 5'd8, 5'd0, 6'h20); in_ctrl = 8'h05; in_pc4 = 32'h404;
      flush = 1'b1;
      tick(1'b0);
      check("flush_valid", {31'h0, out_valid}, 32'h0);
      flush = 1'b0;
      tick(1'b1);
      check("post_flush_valid", {31'h0, out_valid}, 32'h1);
      in_valid = 1'b0;
      tick(1'b0);

      // Sticky halt: output drains, input refused.
      in_valid = 1'b1; in_inst = mk_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20); in_pc4 = 32'h500;
      tick(1'b1);
      in_valid = 1'b0; out_ready = 1'b0; halt_in = 1'b1;
      tick(1'b0);
      halt_in = 1'b0;
      check("halted_set", {31'h0, halted}, 32'h1);
      check("halt_hold_valid", {31'h0, out_valid}, 32'h1);
      in_valid = 1'b1; in_inst = mk_r(5'd8, 5'd0, 5'd9, 5'd0, 6'h20); in_pc4 = 32'h504;
      wb_we = 1'b1; wb_num = 5'd8; wb_data = 32'h0000_0055;
      tick(1'b0);
      out_ready = 1'b1;
      tick(1'b0);
      check("halt_drained", {31'h0, out_valid}, 32'h0);
      tick(1'b0);
      check("halted_sticky", {31'h0, halted}, 32'h1);

      // Reset clears halt; next instruction is taken on the first cycle out of reset.
      rst_b = 1'b1;
      tick(1'b0);
      check("reset_halted", {31'h0, halted}, 32'h0);
      check("reset_valid", {31'h0, out_valid}, 32'h0);
      rst_b = 1'b0;
      tick(1'b1);
      check("post_reset_valid", {31'h0, out_valid}, 32'h1);
      in_valid = 1'b0; wb_we = 1'b0;
      tick(1'b0);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised instruction-decode stage for the MIPS pipeline; successor to the combinational decode block.
- Adds the following to decode and register read:
  - an internal ID/EX pipeline register with valid/ready handshake
  - write-back bypass
  - load-use hazard stall
  - flush
  - sticky halt
- Sits between the IF/ID register and the execute stage. Receives pre-decoded control bits from the external controller.

Parameters:
- XLEN, 32, data width of registers, pc4 and immediate.
- NREG, 32, number of architectural registers. Power of two, ≥2. Register 0 is hardwired to zero.
- RA_W, $clog2(NREG), register-number width.
- CTRL_W, 8, width of control bundle. Must be ≥4. Bit0 reg_write, bit1 mem_read, bits[3:2] dst_sel; upper bits are passed through untouched.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset. Synchronous, active-high: 1 = reset.
- flush  in  1  kill the pipeline register contents and refuse input this cycle.
- in_valid  in  1  IF/ID holds an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc4  in  XLEN  PC+4 of the instruction.
- in_ctrl  in  CTRL_W  controller bundle.
- in_imm_unsigned  in  1  1 = zero-extend inst[15:0], 0 = sign-extend.
- wb_we  in  1  write-back enable.
- wb_num  in  RA_W  write-back register.
- wb_data  in  XLEN  write-back data.
- halt_in  in  1  halt request from the last stage.
- out_valid  out  1  pipeline register holds a valid instruction.
- out_ready  in  1  execute stage consumes this cycle.
- out_rs_data, out_rt_data  out  XLEN  operand values.
- out_imm  out  XLEN  extended immediate.
- out_pc4  out  XLEN  registered in_pc4.
- out_ctrl  out  CTRL_W  registered in_ctrl.
- out_dst  out  RA_W  resolved destination register.
- out_rs_num, out_rt_num  out  RA_W  source register numbers, for downstream forwarding.
- out_shamt  out  5  inst[10:6].
- out_funct  out  6  inst[5:0].
- halted  out  1  sticky halt flag.

Behaviour:
- Field extraction:
  - rs = inst[25:21] and rt = inst[20:16], truncated or zero-padded to RA_W.
  - rd = inst[15:11].
- Destination resolution by dst_sel:
  - 00 → rt
  - 01 → rd
  - 10 → NREG-1 (ra)
  - 11 → 0
- Register file:
  - NREG×XLEN registers, all cleared on reset.
  - Written on the clk edge when wb_we=1, wb_num≠0 and halted=0.
  - Reads of register 0 always return 0.
- Bypass: if wb_we=1 and wb_num≠0 and wb_num equals the read index, the operand equals wb_data in the same cycle (write-first).
- Immediate:
  - in_imm_unsigned=1 → zero-extend inst[15:0] to XLEN.
  - in_imm_unsigned=0 → sign-extend inst[15:0] to XLEN.
- Hazard: hazard = out_valid & out_ctrl[1] & (out_dst≠0) & (out_dst==rs | out_dst==rt).
- Handshake: in_ready = ~rst_b & ~flush & ~halted & ~hazard & (~out_valid | out_ready). A transfer occurs when in_valid & in_ready.
- Pipeline register update, in priority order:
  1. rst_b → all outputs 0, including out_valid and halted.
  2. flush → out_valid=0; data fields are don't-care.
  3. (~out_valid | out_ready) & transfer → load all fields and set out_valid=1.
  4. (~out_valid | out_ready) & ~transfer → out_valid=0, i.e. a bubble. On a hazard this inserts exactly one bubble; the hazard clears the next cycle.
  5. Otherwise hold all fields. Holding must be stable for any number of cycles.
- Latency: one cycle from accepted input to out_valid. Throughput: one instruction per cycle absent hazards or stalls.
- Halt:
  - halted is set on the edge after halt_in=1 and stays set until reset.
  - While halted: in_ready=0 and the register file is frozen.
  - out_valid drains normally.
- Simultaneous flush and hazard: flush wins.
- Write-back to the hazard register during a stall is bypassed normally when the instruction is finally accepted.
- Reset mid-stall clears everything; the next instruction is accepted in the first cycle after reset deasserts.

Test Plan:
- Reset, then write r5=0x1234 via wb, then issue inst with rs=5, rt=0 → next cycle out_rs_data=0x1234, out_rt_data=0, out_valid=1.
- Same cycle: wb_we=1, wb_num=7, wb_data=0xDEADBEEF, and an instruction reading rs=7 → out_rs_data=0xDEADBEEF (bypass). A write to r0 reads back 0.
- Load to rt=3 (ctrl=0x03, dst_sel=00) followed by an instruction with rs=3 → in_ready=0 for one cycle, one bubble (out_valid=0), accepted the following cycle.
- Hold out_ready=0 for 4 cycles with a valid output → all out_* stable, in_ready=0. Release → next instruction loads on the following edge.
- inst[15:0]=0x8001 → out_imm=0xFFFF8001 when signed, 0x00008001 when unsigned. dst_sel=10 → out_dst=31.
- Assert flush during a hazard → out_valid=0 next cycle. Assert halt_in → halted=1 sticky, in_ready=0, wb writes ignored, until rst_b=1.
